// File: rtl/pipeline_ifetch_responder.sv
// rtl/pipeline_ifetch_responder.sv - instruction fetch responder with ROM/DRAM split and one-line buffer
module pipeline_ifetch_responder #(
   parameter logic [63:0] DRAM_BASE = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [63:0] fetch_addr,
   input  logic        flush,
   input  logic        fence_i,
   output logic        if_channel_sel,
   output logic [31:0] dram_dout,
   output logic        dram_data_ready,
   output logic        fetch_busy,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ack,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

   state_t      state;
   logic        buf_valid;
   logic [60:0] buf_tag;
   logic [63:0] buf_data;
   logic        drop;
   logic        fence_seen;
   logic [63:2] req_addr;
   logic        ready_q;

   logic        is_dram;
   logic        is_hit;
   logic        unused_addr_lsbs;

   assign is_dram          = (fetch_addr >= DRAM_BASE);
   assign is_hit           = buf_valid && (fetch_addr[63:3] == buf_tag) && !fence_i;
   assign unused_addr_lsbs = ^fetch_addr[1:0];

   // A miss response is launched at the ack edge; a flush landing in RESP still masks it.
   assign dram_data_ready  = ready_q && !((state == RESP) && flush);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         buf_valid      <= 1'b0;
         buf_tag        <= '0;
         buf_data       <= '0;
         drop           <= 1'b0;
         fence_seen     <= 1'b0;
         req_addr       <= '0;
         ready_q        <= 1'b0;
         if_channel_sel <= 1'b0;
         dram_dout      <= '0;
         fetch_busy     <= 1'b0;
         mem_req        <= 1'b0;
         mem_addr       <= '0;
      end else begin
         ready_q <= 1'b0;
         if (fence_i)
            buf_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (fetch_req && !flush) begin
                  if_channel_sel <= is_dram;
                  if (is_dram) begin
                     if (is_hit) begin
                        dram_dout <= fetch_addr[2] ? buf_data[63:32] : buf_data[31:0];
                        ready_q   <= 1'b1;
                     end else begin
                        req_addr   <= fetch_addr[63:2];
                        mem_req    <= 1'b1;
                        mem_addr   <= {fetch_addr[63:3], 3'b000};
                        fetch_busy <= 1'b1;
                        drop       <= 1'b0;
                        fence_seen <= 1'b0;
                        state      <= MISS;
                     end
                  end
               end
            end

            MISS: begin
               if (flush)
                  drop <= 1'b1;
               if (fence_i)
                  fence_seen <= 1'b1;
               if (mem_ack) begin
                  buf_data  <= mem_rdata;
                  buf_tag   <= req_addr[63:3];
                  buf_valid <= !(fence_seen || fence_i);
                  mem_req   <= 1'b0;
                  state     <= RESP;
                  if (!(drop || flush)) begin
                     dram_dout <= req_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                     ready_q   <= 1'b1;
                  end
               end
            end

            RESP: begin
               fetch_busy <= 1'b0;
               drop       <= 1'b0;
               state      <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_ifetch_responder.sv
// tb/tb_pipeline_ifetch_responder.sv - table-driven and randomized checks of pipeline_ifetch_responder
module tb_pipeline_ifetch_responder;

   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [63:0] fetch_addr;
   logic        flush;
   logic        fence_i;
   logic        if_channel_sel;
   logic [31:0] dram_dout;
   logic        dram_data_ready;
   logic        fetch_busy;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [63:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [63:0] addr;
      logic        fence;
      logic        flush_m;
      logic        fence_m;
      int          delay;
      logic [63:0] rdata;
      logic        exp_miss;
      logic        exp_ready;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs [10];

   pipeline_ifetch_responder #(.DRAM_BASE(BASE)) dut (
      .clk             (clk),
      .reset           (reset),
      .fetch_req       (fetch_req),
      .fetch_addr      (fetch_addr),
      .flush           (flush),
      .fence_i         (fence_i),
      .if_channel_sel  (if_channel_sel),
      .dram_dout       (dram_dout),
      .dram_data_ready (dram_data_ready),
      .fetch_busy      (fetch_busy),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_fetch(input vec_t v);
      fetch_req  = 1'b1;
      fetch_addr = v.addr;
      fence_i    = v.fence;
      tick();
      fetch_req = 1'b0;
      fence_i   = 1'b0;
      chk("chan", 64'(if_channel_sel), 64'(v.addr >= BASE));
      if (v.exp_miss) begin
         chk("miss_req", 64'(mem_req), 64'(1));
         chk("miss_addr", mem_addr, {v.addr[63:3], 3'b000});
         chk("miss_busy", 64'(fetch_busy), 64'(1));
         for (int k = 0; k <= v.delay; k++) begin
            flush     = v.flush_m && (k == 0);
            fence_i   = v.fence_m && (k == 0);
            mem_ack   = (k == v.delay);
            mem_rdata = v.rdata;
            tick();
            flush   = 1'b0;
            fence_i = 1'b0;
            mem_ack = 1'b0;
            if (k < v.delay) begin
               chk("hold_req", 64'(mem_req), 64'(1));
               chk("hold_addr", mem_addr, {v.addr[63:3], 3'b000});
            end
         end
         chk("resp_ready", 64'(dram_data_ready), 64'(v.exp_ready));
         if (v.exp_ready)
            chk("resp_dout", 64'(dram_dout), 64'(v.exp_dout));
         chk("resp_req_low", 64'(mem_req), 64'(0));
         tick();
         chk("busy_clear", 64'(fetch_busy), 64'(0));
         chk("pulse_one_cycle", 64'(dram_data_ready), 64'(0));
      end else begin
         chk("no_req", 64'(mem_req), 64'(0));
         chk("ready", 64'(dram_data_ready), 64'(v.exp_ready));
         if (v.exp_ready)
            chk("dout", 64'(dram_dout), 64'(v.exp_dout));
      end
   endtask

   logic        mv;
   logic [60:0] mtag;
   logic [63:0] mdata;
   logic [63:0] la;
   logic        dram;
   logic        hit;
   vec_t        rv;

   initial begin
      vecs[0] = '{64'h1000,          1'b0, 1'b0, 1'b0, 0, 64'h0,                   1'b0, 1'b0, 32'h0};
      vecs[1] = '{BASE,              1'b0, 1'b0, 1'b0, 3, 64'h0010_0093_0000_0013, 1'b1, 1'b1, 32'h0000_0013};
      vecs[2] = '{BASE + 64'h4,      1'b0, 1'b0, 1'b0, 0, 64'h0,                   1'b0, 1'b1, 32'h0010_0093};
      vecs[3] = '{BASE + 64'h8,      1'b0, 1'b1, 1'b0, 2, 64'hAAAA_1111_BBBB_2222, 1'b1, 1'b0, 32'h0};
      vecs[4] = '{BASE + 64'hC,      1'b0, 1'b0, 1'b0, 0, 64'h0,                   1'b0, 1'b1, 32'hAAAA_1111};
      vecs[5] = '{BASE + 64'h4,      1'b1, 1'b0, 1'b0, 0, 64'hCAFE_0001_CAFE_0000, 1'b1, 1'b1, 32'hCAFE_0001};
      vecs[6] = '{BASE + 64'h10,     1'b0, 1'b0, 1'b1, 1, 64'h5555_6666_7777_8888, 1'b1, 1'b1, 32'h7777_8888};
      vecs[7] = '{BASE + 64'h14,     1'b0, 1'b0, 1'b0, 1, 64'h5555_6666_7777_8888, 1'b1, 1'b1, 32'h5555_6666};
      vecs[8] = '{BASE + 64'h14,     1'b0, 1'b0, 1'b0, 0, 64'h0,                   1'b0, 1'b1, 32'h5555_6666};
      vecs[9] = '{BASE - 64'h4,      1'b0, 1'b0, 1'b0, 0, 64'h0,                   1'b0, 1'b0, 32'h0};

      reset      = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      flush      = 1'b0;
      fence_i    = 1'b0;
      mem_ack    = 1'b0;
      mem_rdata  = '0;
      tick();
      tick();
      chk("rst_chan", 64'(if_channel_sel), 64'(0));
      chk("rst_dout", 64'(dram_dout), 64'(0));
      chk("rst_ready", 64'(dram_data_ready), 64'(0));
      chk("rst_busy", 64'(fetch_busy), 64'(0));
      chk("rst_req", 64'(mem_req), 64'(0));
      chk("rst_addr", mem_addr, 64'(0));
      reset = 1'b1;

      for (int i = 0; i < 10; i++)
         do_fetch(vecs[i]);

      // reset in the middle of a miss, then a stale ack
      fetch_req  = 1'b1;
      fetch_addr = BASE + 64'h100;
      tick();
      fetch_req = 1'b0;
      chk("rm_req", 64'(mem_req), 64'(1));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rm_req_drop", 64'(mem_req), 64'(0));
      chk("rm_busy", 64'(fetch_busy), 64'(0));
      mem_ack   = 1'b1;
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      mem_ack = 1'b0;
      chk("late_ack_ready", 64'(dram_data_ready), 64'(0));
      chk("late_ack_req", 64'(mem_req), 64'(0));
      fetch_req  = 1'b1;
      fetch_addr = BASE + 64'h100;
      tick();
      fetch_req = 1'b0;
      chk("post_rst_miss", 64'(mem_req), 64'(1));
      mem_ack   = 1'b1;
      mem_rdata = 64'h1111_2222_3333_4444;
      tick();
      mem_ack = 1'b0;
      chk("post_rst_ready", 64'(dram_data_ready), 64'(1));
      chk("post_rst_dout", 64'(dram_dout), 64'h3333_4444);
      tick();

      // fetch ignored while busy, flush during RESP, flush with a hit in IDLE
      fetch_req  = 1'b1;
      fetch_addr = BASE + 64'h200;
      tick();
      fetch_addr = BASE + 64'h300;
      tick();
      fetch_req = 1'b0;
      chk("busy_ignore_addr", mem_addr, BASE + 64'h200);
      mem_ack   = 1'b1;
      mem_rdata = 64'h9999_0000_8888_0000;
      tick();
      mem_ack = 1'b0;
      flush   = 1'b1;
      #1;
      chk("resp_flush", 64'(dram_data_ready), 64'(0));
      tick();
      flush = 1'b0;
      chk("resp_flush_busy", 64'(fetch_busy), 64'(0));
      fetch_req  = 1'b1;
      fetch_addr = BASE + 64'h204;
      flush      = 1'b1;
      tick();
      fetch_req = 1'b0;
      flush     = 1'b0;
      chk("hit_flush_ready", 64'(dram_data_ready), 64'(0));
      chk("hit_flush_req", 64'(mem_req), 64'(0));
      fetch_req  = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("hit_after_rflush", 64'(dram_data_ready), 64'(1));
      chk("hit_after_rflush_dout", 64'(dram_dout), 64'h9999_0000);
      chk("hit_after_rflush_req", 64'(mem_req), 64'(0));

      // randomized traffic against a transaction-level line model
      reset = 1'b0;
      tick();
      reset = 1'b1;
      mv    = 1'b0;
      mtag  = '0;
      mdata = '0;
      for (int i = 0; i < 80; i++) begin
         rv.addr    = BASE - 64'd32 + 64'($urandom_range(0, 39) * 4);
         rv.fence   = ($urandom_range(0, 7) == 0);
         rv.flush_m = ($urandom_range(0, 5) == 0);
         rv.fence_m = ($urandom_range(0, 7) == 0);
         rv.delay   = int'($urandom_range(0, 3));
         la         = {rv.addr[63:3], 3'b000};
         rv.rdata   = {la[31:0] ^ 32'hDEAD_BEEF, la[31:0] + 32'h0101_0101};
         dram       = (rv.addr >= BASE);
         if (rv.fence)
            mv = 1'b0;
         hit         = dram && mv && (mtag == rv.addr[63:3]);
         rv.exp_miss = dram && !hit;
         rv.exp_dout = '0;
         if (hit) begin
            rv.exp_ready = 1'b1;
            rv.exp_dout  = rv.addr[2] ? mdata[63:32] : mdata[31:0];
         end else if (dram) begin
            rv.exp_ready = !rv.flush_m;
            rv.exp_dout  = rv.addr[2] ? rv.rdata[63:32] : rv.rdata[31:0];
            mv           = !rv.fence_m;
            mtag         = rv.addr[63:3];
            mdata        = rv.rdata;
         end else begin
            rv.exp_ready = 1'b0;
         end
         do_fetch(rv);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
